// File: rtl/exibidor_sequencia.sv
// Plays the stored colour sequence on the RGB LEDs: each element is lit for T_ON cycles, then dark for T_OFF cycles.
// Optional macro ACELERA_EN: a latched 'rapido' request halves both on and off times.
module exibidor_sequencia #(
  parameter int ADDR_W = 4,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        dado_mem,
  input  logic              rapido,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           state_reg, state_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] limite_reg, limite_next;
  logic [3:0]        cor_reg, cor_next;
  logic [3:0]        leds_reg, leds_next;
  logic [TW-1:0]     on_last, off_last;

`ifdef ACELERA_EN
  logic rapido_reg, rapido_next;

  assign on_last  = rapido_reg ? TW'((T_ON >> 1) - 1)  : TW'(T_ON - 1);
  assign off_last = rapido_reg ? TW'((T_OFF >> 1) - 1) : TW'(T_OFF - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      rapido_reg <= 1'b0;
    end else begin
      rapido_reg <= rapido_next;
    end
  end

  always_comb begin
    rapido_next = rapido_reg;
    if (state_reg == OCIOSO && iniciar && !abortar) begin
      rapido_next = rapido;
    end
  end
`else
  logic unused_rapido;

  assign unused_rapido = rapido;
  assign on_last       = TW'(T_ON - 1);
  assign off_last      = TW'(T_OFF - 1);
`endif

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    addr_next   = addr_reg;
    limite_next = limite_reg;
    cor_next    = cor_reg;

    case (state_reg)
      OCIOSO: begin
        if (iniciar && !abortar) begin
          state_next  = CARREGA;
          addr_next   = '0;
          limite_next = limite;
        end
      end
      CARREGA: begin
        cor_next   = dado_mem;
        timer_next = '0;
        state_next = ACESO;
      end
      ACESO: begin
        if (timer_reg == on_last) begin
          timer_next = '0;
          state_next = APAGADO;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      APAGADO: begin
        if (timer_reg == off_last) begin
          timer_next = '0;
          state_next = (addr_reg == limite_reg) ? FIM : PROXIMO;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      PROXIMO: begin
        addr_next  = addr_reg + 1'b1;
        state_next = CARREGA;
      end
      FIM: begin
        addr_next  = '0;
        state_next = OCIOSO;
      end
      default: begin
        // Unreachable codes 6 and 7 recover to idle.
        addr_next  = '0;
        timer_next = '0;
        state_next = OCIOSO;
      end
    endcase

    if (abortar && state_reg != OCIOSO) begin
      addr_next  = '0;
      timer_next = '0;
      state_next = OCIOSO;
    end

    // LEDs are registered, so look one state ahead to keep them aligned with ACESO.
    leds_next = (state_next == ACESO) ? cor_next : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= OCIOSO;
      timer_reg  <= '0;
      addr_reg   <= '0;
      limite_reg <= '0;
      cor_reg    <= 4'd0;
      leds_reg   <= 4'd0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      addr_reg   <= addr_next;
      limite_reg <= limite_next;
      cor_reg    <= cor_next;
      leds_reg   <= leds_next;
    end
  end

  assign endereco  = addr_reg;
  assign leds      = leds_reg;
  assign ocupado   = (state_reg != OCIOSO);
  assign pronto    = (state_reg == FIM);
  assign db_estado = state_reg;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench for exibidor_sequencia: a per-cycle expected trace is queued at start and
// compared against the outputs by a negedge scoreboard monitor.
module tb_exibidor_sequencia;

  localparam int AW   = 4;
  localparam int TON  = 4;
  localparam int TOFF = 2;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          iniciar = 1'b0;
  logic          abortar = 1'b0;
  logic          rapido  = 1'b0;
  logic [AW-1:0] limite  = '0;
  logic [3:0]    dado_mem;
  logic [AW-1:0] endereco;
  logic [3:0]    leds;
  logic          ocupado;
  logic          pronto;
  logic [2:0]    db_estado;

  logic [3:0] mem [16];

  exibidor_sequencia #(.ADDR_W(AW), .T_ON(TON), .T_OFF(TOFF)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .limite(limite), .dado_mem(dado_mem), .rapido(rapido),
    .endereco(endereco), .leds(leds), .ocupado(ocupado), .pronto(pronto),
    .db_estado(db_estado)
  );

  assign dado_mem = mem[endereco];

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]    leds;
    logic [AW-1:0] ender;
    logic          pronto;
    logic          ocupado;
    logic [2:0]    est;
  } obs_t;

  obs_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;
  int   mon_cyc = 0;

  function automatic obs_t mk(input logic [3:0] l, input int e, input logic p, input logic o,
                              input logic [2:0] s);
    obs_t r;
    r.leds = l; r.ender = AW'(e); r.pronto = p; r.ocupado = o; r.est = s;
    return r;
  endfunction

  // Expected cycle-by-cycle outputs starting at cycle 1 (first cycle after iniciar is sampled).
  function automatic void push_play(input int lim, input int ton, input int toff);
    for (int e = 0; e <= lim; e++) begin
      sb.push_back(mk(4'd0, e, 1'b0, 1'b1, 3'd1));
      for (int i = 0; i < ton; i++) sb.push_back(mk(mem[e], e, 1'b0, 1'b1, 3'd2));
      for (int i = 0; i < toff; i++) sb.push_back(mk(4'd0, e, 1'b0, 1'b1, 3'd3));
      if (e < lim) sb.push_back(mk(4'd0, e, 1'b0, 1'b1, 3'd4));
      else         sb.push_back(mk(4'd0, e, 1'b1, 1'b1, 3'd5));
    end
    sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 3'd0));
  endfunction

  always @(negedge clock) begin
    obs_t exp_v;
    obs_t act_v;
    if (mon_en && sb.size() > 0) begin
      exp_v = sb.pop_front();
      act_v = {leds, endereco, pronto, ocupado, db_estado};
      mon_cyc++;
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL trace cycle %0d: got leds=%b end=%0d pronto=%b ocupado=%b estado=%0d, expected leds=%b end=%0d pronto=%b ocupado=%b estado=%0d",
                 mon_cyc, act_v.leds, act_v.ender, act_v.pronto, act_v.ocupado, act_v.est,
                 exp_v.leds, exp_v.ender, exp_v.pronto, exp_v.ocupado, exp_v.est);
      end
    end
  end

  // Pulse iniciar in cycle 0 and arm the monitor for cycle 1.
  task automatic start_and_arm();
    @(posedge clock); #1 iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    mon_cyc = 0;
    mon_en  = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output int left);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(posedge clock); #1;
    end
    left   = sb.size();
    mon_en = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    int seen_pronto;
    @(posedge clock); #1;
    checks++;
    if ({leds, endereco, pronto, ocupado, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_powerup: got leds=%b end=%0d pronto=%b ocupado=%b estado=%0d, expected all 0",
               leds, endereco, pronto, ocupado, db_estado);
    end
    reset   = 1'b0;
    limite  = 4'd2;
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    @(posedge clock); #1 iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    checks++;
    if ({leds, endereco, pronto, ocupado, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_midplay: got leds=%b end=%0d pronto=%b ocupado=%b estado=%0d, expected all 0",
               leds, endereco, pronto, ocupado, db_estado);
    end
    seen_pronto = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (pronto !== 1'b0 || db_estado !== 3'd0) seen_pronto++;
    end
    checks++;
    if (seen_pronto != 0) begin
      errors++;
      $display("FAIL reset_no_pronto: got %0d active cycles, expected 0", seen_pronto);
    end
  endtask

  task automatic test_single();
    int left;
    limite = 4'd0;
    mem[0] = 4'b0010;
    push_play(0, TON, TOFF);
    start_and_arm();
    wait_drain(40, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL single_timeout: got %0d pending, expected 0", left);
    end
  endtask

  task automatic test_three();
    int left;
    limite = 4'd2;
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    push_play(2, TON, TOFF);
    start_and_arm();
    wait_drain(60, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL three_timeout: got %0d pending, expected 0", left);
    end
  endtask

  task automatic test_abort();
    int left;
    limite = 4'd2;
    push_play(2, TON, TOFF);
    while (sb.size() > 11) void'(sb.pop_back());
    for (int i = 0; i < 6; i++) sb.push_back(mk(4'd0, 0, 1'b0, 1'b0, 3'd0));
    start_and_arm();
    repeat (10) @(posedge clock);
    #1 abortar = 1'b1;
    @(posedge clock); #1 abortar = 1'b0;
    wait_drain(40, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL abort_timeout: got %0d pending, expected 0", left);
    end
    push_play(2, TON, TOFF);
    start_and_arm();
    wait_drain(60, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL abort_replay_timeout: got %0d pending, expected 0", left);
    end
  endtask

  task automatic test_ignored_inputs();
    int left;
    limite = 4'd2;
    push_play(2, TON, TOFF);
    start_and_arm();
    for (int c = 1; c <= 26; c++) begin
      iniciar = (c == 3 || c == 7 || c == 12 || c == 20);
      if (c == 5) limite = 4'd0;
      if (c == 6) rapido = 1'b1;
      @(posedge clock); #1;
    end
    iniciar = 1'b0;
    limite  = 4'd2;
    rapido  = 1'b0;
    wait_drain(20, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL ignored_timeout: got %0d pending, expected 0", left);
    end
    @(posedge clock); #1 iniciar = 1'b1; abortar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0; abortar = 1'b0;
    checks++;
    if (db_estado !== 3'd0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: got estado=%0d ocupado=%b, expected estado=0 ocupado=0",
               db_estado, ocupado);
    end
    @(posedge clock); #1;
    checks++;
    if (db_estado !== 3'd0 || leds !== 4'd0) begin
      errors++;
      $display("FAIL start_abort_stay: got estado=%0d leds=%b, expected estado=0 leds=0000",
               db_estado, leds);
    end
  endtask

  task automatic test_acelera();
    int left;
    limite = 4'd0;
    mem[0] = 4'b0110;
    rapido = 1'b1;
`ifdef ACELERA_EN
    push_play(0, TON >> 1, TOFF >> 1);
`else
    push_play(0, TON, TOFF);
`endif
    start_and_arm();
    rapido = 1'b0;
    wait_drain(40, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL acelera_fast_timeout: got %0d pending, expected 0", left);
    end
    rapido = 1'b0;
    push_play(0, TON, TOFF);
    start_and_arm();
    wait_drain(40, left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL acelera_slow_timeout: got %0d pending, expected 0", left);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    test_reset();
    test_single();
    test_three();
    test_abort();
    test_ignored_inputs();
    test_acelera();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exibidor_sequencia.md
Name: exibidor_sequencia

Overview:
Display sequencer that plays the stored colour sequence on the RGB LEDs during the game's exhibition phase. It owns the memory read address and the on/off LED timer for that phase. The main game FSM hands it a start pulse and the last index, then waits for its done pulse before entering the response phase.

Parameters:
ADDR_W, 4, width of sequence memory address and of limite.
T_ON, 1000, clock cycles each colour is lit (>=2).
T_OFF, 500, clock cycles LEDs stay dark after each colour (>=2).

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; one clock edge with reset=1 forces the reset state
iniciar  in  1  start request, sampled only in OCIOSO
abortar  in  1  cancel playback, sampled every cycle
limite  in  ADDR_W  index of last element to show (inclusive); latched on start
dado_mem  in  4  colour at endereco from sequence memory (combinational read)
rapido  in  1  fast-mode request; used only with ACELERA_EN
endereco  out  ADDR_W  memory read address
leds  out  4  colour driven to LEDs; 0 = dark
ocupado  out  1  high in every state except OCIOSO
pronto  out  1  one-cycle pulse when full sequence shown
db_estado  out  3  current state code

Behaviour:
- Reset: state OCIOSO, endereco=0, leds=0, ocupado=0, pronto=0, timer=0, latched colour/limite/rapido=0.
- States and codes: OCIOSO=0, CARREGA=1, ACESO=2, APAGADO=3, PROXIMO=4, FIM=5. Codes 6 and 7 are illegal; both go to OCIOSO on the next edge.
- OCIOSO: iniciar=1 and abortar=0 -> CARREGA. On that edge endereco<=0, limite and rapido are latched.
- CARREGA, 1 cycle: latch dado_mem into the colour register, clear timer -> ACESO.
- ACESO: leds=latched colour. Timer counts 0..T_ON_eff-1. At the edge where timer==T_ON_eff-1, go to APAGADO and clear timer.
- APAGADO: leds=0. Timer counts 0..T_OFF_eff-1. At the last count, go to FIM if endereco==latched limite, else go to PROXIMO.
- PROXIMO, 1 cycle: endereco<=endereco+1 -> CARREGA.
- FIM, 1 cycle: pronto=1, endereco<=0 -> OCIOSO.
- leds are registered from the state and colour register: 0 in every state except ACESO.
- Without ACELERA_EN: T_ON_eff=T_ON and T_OFF_eff=T_OFF.
- Timer width: $clog2(max(T_ON,T_OFF)+1). The timer never wraps.
- Latency for N=limite+1 elements: pronto is high in cycle N*(2+T_ON+T_OFF), counted from the first cycle after iniciar was sampled (cycle 1 = CARREGA).
- endereco never exceeds limite. limite=0 shows exactly one element.
- iniciar outside OCIOSO is ignored, with no effect on state, address or latched values.
- abortar=1 in any state other than OCIOSO: next state OCIOSO, endereco<=0, leds=0, no pronto pulse.
- abortar and iniciar both 1 in OCIOSO: abortar wins, stay in OCIOSO.
- abortar in FIM: pronto is already high that cycle; next state is OCIOSO either way.
- Reset mid-playback: same effect as power-on reset on the next edge, with no pronto.
- Changes to limite, rapido or dado_mem during playback have no effect except dado_mem sampled in CARREGA.

Optional Feature:
ACELERA_EN.
- Defined: rapido is latched on start. If the latched value is 1, T_ON_eff=T_ON>>1 and T_OFF_eff=T_OFF>>1, otherwise full values.
- Not defined: rapido port is present but ignored, and the timer logic holds no latch for it.

Test Plan:
1. T_ON=4, T_OFF=2: assert reset one edge mid-operation and from power-up -> next cycle all outputs 0, db_estado=0.
2. limite=0, mem[0]=4'b0010, iniciar pulse:
   - ocupado=1 from cycle 1;
   - leds=0010 in cycles 2-5, 0 in cycles 6-7;
   - pronto=1 only in cycle 8, endereco=0 after;
   - OCIOSO in cycle 9.
3. limite=2, mem={0001,0100,1000}:
   - endereco steps 0 -> 1 at cycle 8 -> 2 at cycle 16;
   - leds show 0001, 0100, 1000 in order, 4 cycles each;
   - pronto=1 only in cycle 24.
4. limite=2, abortar=1 in the 2nd ACESO cycle of element 1:
   - next cycle OCIOSO, leds=0, endereco=0;
   - pronto never pulses;
   - a new iniciar replays from element 0.
5. iniciar pulses during ACESO and APAGADO -> ignored, timing identical to scenario 3. iniciar+abortar together in OCIOSO -> stays OCIOSO.
6. ACELERA_EN defined, rapido=1, limite=0 -> leds lit 2 cycles, dark 1 cycle, pronto in cycle 5. With rapido=0, same timing as scenario 2.
